mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the instruction-fetch stage and the load/store path of the 5-stage pipeline.
- Owns the request/grant handshake and issue sequencing, and returns responses to the correct requester.
- Suppresses stale fetch responses after a branch or jump redirect.
- Fetch stalls whenever `if_gnt` is low while `if_req` is high.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and load/store.
// Combinational grant/issue in the issue slot; one transaction outstanding at a time.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_kill,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] starve, starve_nxt;
  logic          owner_if, owner_if_nxt;
  logic          drop, drop_nxt;
  logic          slot, rsp_rd, pick_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      starve   <= '0;
      owner_if <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      starve   <= starve_nxt;
      owner_if <= owner_if_nxt;
      drop     <= drop_nxt;
    end
  end

  always_comb begin
    rsp_rd = 1'b0;
    slot   = 1'b0;
    // Everything is gated by rst so a reset cycle shows all-zero outputs.
    if (!rst) begin
      rsp_rd = (state == RD_WAIT) && (cnt == CW'(1));
      slot   = (state == IDLE) || (state == WR_ACK) || rsp_rd;
    end
    pick_if = if_req && (!d_req || (starve == SW'(STARVE_MAX)));
    if_gnt  = slot && pick_if;
    d_gnt   = slot && d_req && !pick_if;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      mem_be   = '1;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end

    if_rvalid = rsp_rd && owner_if && !drop && !if_kill;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rvalid  = (rsp_rd && !owner_if) || (!rst && (state == WR_ACK));
    d_rdata   = (rsp_rd && !owner_if) ? mem_rdata : '0;

    state_nxt    = state;
    cnt_nxt      = cnt;
    owner_if_nxt = owner_if;
    drop_nxt     = (state == RD_WAIT) && (drop || if_kill);
    if (state == RD_WAIT) cnt_nxt = cnt - CW'(1);
    if (slot) state_nxt = IDLE;
    if (if_gnt || d_gnt) begin
      owner_if_nxt = if_gnt;
      // A kill coinciding with the fetch grant drops that new fetch.
      drop_nxt     = if_gnt && if_kill;
      if (d_gnt && d_we) begin
        state_nxt = WR_ACK;
        cnt_nxt   = '0;
      end else begin
        state_nxt = RD_WAIT;
        cnt_nxt   = CW'(LAT);
      end
    end

    starve_nxt = starve;
    if (!if_req || if_gnt) starve_nxt = '0;
    else if (d_gnt && (starve != SW'(STARVE_MAX))) starve_nxt = starve + SW'(1);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed literal checks plus randomized traffic against a
// transaction-level model (issue times, single pending response record, starvation count).
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 2;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, if_kill = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_be = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending response record, earliest next issue cycle, starvation count.
  int cyc = 0, next_free = 0, rsp_cyc = 0, rsp_kind = 0, starve_m = 0;
  bit rsp_drop = 1'b0;

  always @(negedge clk) begin : model
    logic e_ig, e_dg, e_iv, e_dv, e_en, e_we;
    logic [31:0] e_ir, e_dr, e_addr, e_wd;
    logic [3:0]  e_be;
    e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_en = 0; e_we = 0;
    e_ir = 0; e_dr = 0; e_addr = 0; e_wd = 0; e_be = 0;
    if (rst) begin
      next_free = cyc + 1;
      rsp_kind  = 0;
      starve_m  = 0;
    end else begin
      if (rsp_kind == 1 && if_kill) rsp_drop = 1'b1;
      if (rsp_kind != 0 && rsp_cyc == cyc) begin
        if (rsp_kind == 1) begin
          e_iv = !rsp_drop;
          e_ir = rsp_drop ? 32'h0 : mem_rdata;
        end else if (rsp_kind == 2) begin
          e_dv = 1; e_dr = mem_rdata;
        end else begin
          e_dv = 1;
        end
        rsp_kind = 0;
      end
      if (cyc >= next_free) begin
        if (if_req && (!d_req || starve_m == SMAX)) begin
          e_ig = 1; e_en = 1; e_addr = if_addr; e_be = 4'hF;
          rsp_kind = 1; rsp_cyc = cyc + LAT; rsp_drop = if_kill; next_free = cyc + LAT;
        end else if (d_req) begin
          e_dg = 1; e_en = 1; e_we = d_we; e_addr = d_addr; e_wd = d_wdata; e_be = d_be;
          rsp_kind = d_we ? 3 : 2;
          rsp_cyc  = d_we ? cyc + 1 : cyc + LAT;
          next_free = rsp_cyc;
        end
      end
      if (!if_req || e_ig) starve_m = 0;
      else if (e_dg && starve_m < SMAX) starve_m++;
    end
    chk("if_gnt", 64'(if_gnt), 64'(e_ig));
    chk("d_gnt", 64'(d_gnt), 64'(e_dg));
    chk("if_rvalid", 64'(if_rvalid), 64'(e_iv));
    chk("if_rdata", 64'(if_rdata), 64'(e_ir));
    chk("d_rvalid", 64'(d_rvalid), 64'(e_dv));
    chk("d_rdata", 64'(d_rdata), 64'(e_dr));
    chk("mem_en", 64'(mem_en), 64'(e_en));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    chk("mem_be", 64'(mem_be), 64'(e_be));
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_req = 0; d_req = 0; d_we = 0; if_kill = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin : stim
    string seq;
    bit gi, gd;

    // Reset, then a continuous fetch stream from 0x100.
    step(); step();
    rst = 0; if_req = 1; if_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_gnt_c1", 64'(if_gnt), 64'd1);
    chk("t1_addr_c1", 64'(mem_addr), 64'h100);
    chk("t1_be_c1", 64'(mem_be), 64'hF);
    step(); @(negedge clk);
    chk("t1_gnt_c2", 64'(if_gnt), 64'd0);
    chk("t1_rv_c2", 64'(if_rvalid), 64'd0);
    step(); @(negedge clk);
    chk("t1_rv_c3", 64'(if_rvalid), 64'd1);
    chk("t1_rdata_c3", 64'(if_rdata), 64'hDEADBEEF);
    chk("t1_gnt_c3", 64'(if_gnt), 64'd1);
    step(); quiet(); drain(3);

    // Starvation: both requesters hold loads/fetches continuously.
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h1000;
    seq = "";
    for (int i = 0; i < 40 && seq.len() < 8; i++) begin
      @(negedge clk);
      if (if_gnt) seq = {seq, "I"};
      if (d_gnt) seq = {seq, "D"};
      step();
    end
    checks++;
    if (seq != "DDDIDDDI") begin
      errors++;
      $display("FAIL t2_grant_order: got %s expected DDDIDDDI", seq);
    end
    quiet(); drain(3);

    // Store beats a simultaneous fetch; fetch issues in the ack cycle.
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_be = 4'b0011;
    if_req = 1; if_addr = 32'h300;
    @(negedge clk);
    chk("t3_dgnt", 64'(d_gnt), 64'd1);
    chk("t3_we", 64'(mem_we), 64'd1);
    chk("t3_be", 64'(mem_be), 64'h3);
    chk("t3_wdata", 64'(mem_wdata), 64'h12345678);
    step(); d_req = 0; d_we = 0; @(negedge clk);
    chk("t3_ack", 64'(d_rvalid), 64'd1);
    chk("t3_ack_data", 64'(d_rdata), 64'd0);
    chk("t3_if_gnt", 64'(if_gnt), 64'd1);
    step(); quiet(); drain(3);

    // Kill after a fetch grant suppresses its response only.
    if_req = 1; if_addr = 32'h400;
    @(negedge clk);
    chk("t4_gnt", 64'(if_gnt), 64'd1);
    step(); if_req = 0; if_kill = 1;
    step(); if_kill = 0; if_req = 1; if_addr = 32'h404; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("t4_killed_rv", 64'(if_rvalid), 64'd0);
    chk("t4_regnt", 64'(if_gnt), 64'd1);
    step(); if_req = 0;
    step(); @(negedge clk);
    chk("t4_rv", 64'(if_rvalid), 64'd1);
    chk("t4_rdata", 64'(if_rdata), 64'hCAFEF00D);
    step(); quiet(); drain(2);

    // Reset during an outstanding load discards it; pending request re-granted afterwards.
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    @(negedge clk);
    chk("t5_gnt", 64'(d_gnt), 64'd1);
    step(); rst = 1; @(negedge clk);
    chk("t5_en_rst", 64'(mem_en), 64'd0);
    step(); @(negedge clk);
    chk("t5_rv_rst", 64'(d_rvalid), 64'd0);
    chk("t5_gnt_rst", 64'(d_gnt), 64'd0);
    step(); rst = 0; @(negedge clk);
    chk("t5_regnt", 64'(d_gnt), 64'd1);
    step(); quiet(); drain(3);

    // A data request pulsed while a read is outstanding is never issued.
    if_req = 1; if_addr = 32'h500;
    step(); if_req = 0; d_req = 1; d_addr = 32'h6000; @(negedge clk);
    chk("t6_dgnt", 64'(d_gnt), 64'd0);
    chk("t6_en", 64'(mem_en), 64'd0);
    step(); d_req = 0; @(negedge clk);
    chk("t6_en_after", 64'(mem_en), 64'd0);
    chk("t6_rv", 64'(if_rvalid), 64'd1);

    // Randomized traffic; requesters hold until granted, sometimes give up.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      gi = if_gnt; gd = d_gnt;
      step();
      if (!if_req || gi) begin
        if_req = ($urandom_range(3) != 0); if_addr = $urandom;
      end else if ($urandom_range(15) == 0) if_req = 0;
      if (!d_req || gd) begin
        d_req = ($urandom_range(2) != 0); d_we = $urandom_range(1);
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom_range(15));
      end else if ($urandom_range(15) == 0) d_req = 0;
      if_kill   = ($urandom_range(9) == 0);
      rst       = ($urandom_range(199) == 0);
      mem_rdata = $urandom;
    end
    rst = 0; quiet(); drain(4);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
